// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/freeze enables for the 5-stage core,
// EX-stage forwarding selects, memory-wait timeout and saturating perf counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memRead,
    input  logic             ex_regWrite,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regWrite,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regWrite,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;

    localparam logic [4:0]       TIMEOUT = 5'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [4:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic freeze, loaduse, active, branch_apply, loaduse_apply;

    // ex_regWrite is not needed: a load hazard is identified by ex_memRead alone.
    logic unused_ok;
    assign unused_ok = ex_regWrite;

    assign freeze  = mem_req & ~mem_ready;
    assign loaduse = ex_memRead & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    assign active        = (state_q != ERROR);
    assign branch_apply  = active & ~freeze & ex_branch_taken;
    assign loaduse_apply = active & ~freeze & ~ex_branch_taken & loaduse;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // NOTE: every combinational output is given a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d = MEM_WAIT;
                    wait_d  = 5'd1;
                end
            end
            MEM_WAIT: begin
                if (!freeze) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == TIMEOUT) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + 5'd1;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (active & (freeze | loaduse_apply) & (stall_q != '1)) stall_d = stall_q + CNT_ONE;
        if (branch_apply & (flush_q != '1))                      flush_d = flush_q + CNT_ONE;
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (mem_regWrite && mem_rd != 5'd0 && mem_rd == rs)     return 2'b10;
        else if (wb_regWrite && wb_rd != 5'd0 && wb_rd == rs)   return 2'b01;
        else                                                    return 2'b00;
    endfunction

    // Everything is quiet while rst_n is low; otherwise ERROR > freeze > branch > load-use.
    always_comb begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_write   = 1'b0;
        idex_flush   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b0;
        forwardA     = 2'b00;
        forwardB     = 2'b00;
        if (rst_n) begin
            forwardA = fwd_sel(ex_rs1);
            forwardB = fwd_sel(ex_rs2);
            if (!active || freeze) begin
                memwb_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_write  = 1'b1;
                idex_flush  = 1'b1;
                exmem_write = 1'b1;
            end else if (loaduse) begin
                idex_write  = 1'b1;
                idex_flush  = 1'b1;
                exmem_write = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_write  = 1'b1;
                exmem_write = 1'b1;
            end
        end
    end

    assign mem_err   = (state_q == ERROR);
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios on a default instance and a
// small instance (MEM_TIMEOUT=4, CNT_W=2), then random stimulus against a rule-level model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_memRead, ex_regWrite, ex_branch_taken;
    logic       mem_regWrite, mem_req, mem_ready, wb_regWrite;

    logic        pc_write_a, ifid_write_a, ifid_flush_a, idex_write_a, idex_flush_a;
    logic        exmem_write_a, memwb_bubble_a, mem_err_a;
    logic [1:0]  forwardA_a, forwardB_a;
    logic [15:0] stall_cnt_a, flush_cnt_a;

    logic        pc_write_b, ifid_write_b, ifid_flush_b, idex_write_b, idex_flush_b;
    logic        exmem_write_b, memwb_bubble_b, mem_err_b;
    logic [1:0]  forwardA_b, forwardB_b;
    logic [1:0]  stall_cnt_b, flush_cnt_b;

    hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_regWrite(mem_regWrite), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
        .pc_write(pc_write_a), .ifid_write(ifid_write_a), .ifid_flush(ifid_flush_a),
        .idex_write(idex_write_a), .idex_flush(idex_flush_a), .exmem_write(exmem_write_a),
        .memwb_bubble(memwb_bubble_a), .forwardA(forwardA_a), .forwardB(forwardB_a),
        .mem_err(mem_err_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_regWrite(mem_regWrite), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
        .pc_write(pc_write_b), .ifid_write(ifid_write_b), .ifid_flush(ifid_flush_b),
        .idex_write(idex_write_b), .idex_flush(idex_flush_b), .exmem_write(exmem_write_b),
        .memwb_bubble(memwb_bubble_b), .forwardA(forwardA_b), .forwardB(forwardB_b),
        .mem_err(mem_err_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    // Control vector: pc_w, ifid_w, ifid_fl, idex_w, idex_fl, exmem_w, bubble, mem_err, fwdA, fwdB
    logic [11:0] ctl_a, ctl_b;
    assign ctl_a = {pc_write_a, ifid_write_a, ifid_flush_a, idex_write_a, idex_flush_a,
                    exmem_write_a, memwb_bubble_a, mem_err_a, forwardA_a, forwardB_a};
    assign ctl_b = {pc_write_b, ifid_write_b, ifid_flush_b, idex_write_b, idex_flush_b,
                    exmem_write_b, memwb_bubble_b, mem_err_b, forwardA_b, forwardB_b};

    localparam logic [11:0] C_RESET   = 12'b0000_0000_0000;
    localparam logic [11:0] C_NORMAL  = 12'b1101_0100_0000;
    localparam logic [11:0] C_FROZEN  = 12'b0000_0010_0000;
    localparam logic [11:0] C_ERROR   = 12'b0000_0011_0000;
    localparam logic [11:0] C_BRANCH  = 12'b1111_1100_0000;
    localparam logic [11:0] C_LOADUSE = 12'b0001_1100_0000;

    int n_checks = 0;
    int n_errors = 0;

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_memRead = 0; ex_regWrite = 0; ex_rs1 = 0; ex_rs2 = 0; ex_branch_taken = 0;
        mem_rd = 0; mem_regWrite = 0; mem_req = 0; mem_ready = 0;
        wb_rd = 0; wb_regWrite = 0;
    endtask

    // Advance one clock; inputs may change 1 time unit after the edge, checks 2 units later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic set_loaduse();
        ex_memRead = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        cyc();
        // activity on the inputs must stay invisible while reset is held
        ex_branch_taken = 1; mem_regWrite = 1; mem_rd = 7; ex_rs1 = 7; set_loaduse();
        settle();
        n_checks++;
        if (ctl_a !== C_RESET) begin n_errors++; $display("FAIL reset_ctl_a got=%b exp=%b", ctl_a, C_RESET); end
        n_checks++;
        if (ctl_b !== C_RESET) begin n_errors++; $display("FAIL reset_ctl_b got=%b exp=%b", ctl_b, C_RESET); end
        cyc();
        n_checks++;
        if (stall_cnt_a !== 16'd0 || flush_cnt_a !== 16'd0) begin
            n_errors++; $display("FAIL reset_cnt_a stall=%0d flush=%0d exp=0,0", stall_cnt_a, flush_cnt_a);
        end
        clear_inputs();
        rst_n = 1'b1;
        settle();
        n_checks++;
        if (ctl_a !== C_NORMAL) begin n_errors++; $display("FAIL reset_release got=%b exp=%b", ctl_a, C_NORMAL); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_loaduse();
        settle();
        n_checks++;
        if (ctl_a !== C_LOADUSE) begin n_errors++; $display("FAIL loaduse_ctl got=%b exp=%b", ctl_a, C_LOADUSE); end
        n_checks++;
        if (stall_cnt_a !== 16'd0) begin n_errors++; $display("FAIL loaduse_cnt0 got=%0d exp=0", stall_cnt_a); end
        cyc();
        ex_memRead = 0;
        settle();
        n_checks++;
        if (ctl_a !== C_NORMAL) begin n_errors++; $display("FAIL loaduse_after got=%b exp=%b", ctl_a, C_NORMAL); end
        n_checks++;
        if (stall_cnt_a !== 16'd1) begin n_errors++; $display("FAIL loaduse_cnt1 got=%0d exp=1", stall_cnt_a); end
        // rs2 path, and an x0 destination must never stall
        ex_memRead = 1; id_use_rs1 = 0; id_rs2 = 5; id_use_rs2 = 1;
        settle();
        n_checks++;
        if (ctl_a !== C_LOADUSE) begin n_errors++; $display("FAIL loaduse_rs2 got=%b exp=%b", ctl_a, C_LOADUSE); end
        ex_rd = 0; id_rs2 = 0;
        settle();
        n_checks++;
        if (ctl_a !== C_NORMAL) begin n_errors++; $display("FAIL loaduse_x0 got=%b exp=%b", ctl_a, C_NORMAL); end
    endtask

    task automatic test_branch_load_use();
        do_reset();
        set_loaduse();
        ex_branch_taken = 1;
        settle();
        n_checks++;
        if (ctl_a !== C_BRANCH) begin n_errors++; $display("FAIL branch_lu_ctl got=%b exp=%b", ctl_a, C_BRANCH); end
        cyc();
        clear_inputs();
        settle();
        n_checks++;
        if (flush_cnt_a !== 16'd1) begin n_errors++; $display("FAIL branch_lu_flush got=%0d exp=1", flush_cnt_a); end
        n_checks++;
        if (stall_cnt_a !== 16'd0) begin n_errors++; $display("FAIL branch_lu_stall got=%0d exp=0", stall_cnt_a); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++;
            if (ctl_a !== C_FROZEN) begin n_errors++; $display("FAIL memwait_frz%0d got=%b exp=%b", i, ctl_a, C_FROZEN); end
            cyc();
        end
        mem_ready = 1;
        settle();
        n_checks++;
        if (ctl_a !== C_BRANCH) begin n_errors++; $display("FAIL memwait_release got=%b exp=%b", ctl_a, C_BRANCH); end
        cyc();
        clear_inputs();
        settle();
        n_checks++;
        if (ctl_a !== C_NORMAL) begin n_errors++; $display("FAIL memwait_run got=%b exp=%b", ctl_a, C_NORMAL); end
        n_checks++;
        if (stall_cnt_a !== 16'd3 || flush_cnt_a !== 16'd1) begin
            n_errors++; $display("FAIL memwait_cnt stall=%0d flush=%0d exp=3,1", stall_cnt_a, flush_cnt_a);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1; mem_ready = 0;
        // with MEM_TIMEOUT=4 the fifth consecutive frozen edge enters ERROR
        for (int i = 0; i < 5; i++) begin
            settle();
            n_checks++;
            if (ctl_b !== C_FROZEN) begin n_errors++; $display("FAIL timeout_frz%0d got=%b exp=%b", i, ctl_b, C_FROZEN); end
            cyc();
        end
        settle();
        n_checks++;
        if (ctl_b !== C_ERROR) begin n_errors++; $display("FAIL timeout_err got=%b exp=%b", ctl_b, C_ERROR); end
        n_checks++;
        if (ctl_a !== C_FROZEN) begin n_errors++; $display("FAIL timeout_long_frz got=%b exp=%b", ctl_a, C_FROZEN); end
        mem_ready = 1;
        cyc();
        settle();
        n_checks++;
        if (ctl_b !== C_ERROR) begin n_errors++; $display("FAIL timeout_sticky got=%b exp=%b", ctl_b, C_ERROR); end
        rst_n = 0;
        cyc();
        settle();
        n_checks++;
        if (ctl_b !== C_RESET) begin n_errors++; $display("FAIL timeout_rst got=%b exp=%b", ctl_b, C_RESET); end
        rst_n = 1;
        clear_inputs();
        settle();
        n_checks++;
        if (ctl_b !== C_NORMAL) begin n_errors++; $display("FAIL timeout_run got=%b exp=%b", ctl_b, C_NORMAL); end
    endtask

    task automatic test_forwarding();
        do_reset();
        mem_rd = 3; mem_regWrite = 1; wb_rd = 3; wb_regWrite = 1; ex_rs1 = 3; ex_rs2 = 0;
        settle();
        n_checks++;
        if (forwardA_a !== 2'b10 || forwardB_a !== 2'b00) begin
            n_errors++; $display("FAIL fwd_mem A=%b B=%b exp=10,00", forwardA_a, forwardB_a);
        end
        mem_rd = 0;
        settle();
        n_checks++;
        if (forwardA_a !== 2'b01) begin n_errors++; $display("FAIL fwd_wb A=%b exp=01", forwardA_a); end
        ex_rs2 = 3; wb_regWrite = 0;
        settle();
        n_checks++;
        if (forwardA_a !== 2'b00 || forwardB_a !== 2'b00) begin
            n_errors++; $display("FAIL fwd_none A=%b B=%b exp=00,00", forwardA_a, forwardB_a);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_loaduse();
        for (int i = 0; i < 5; i++) cyc();
        clear_inputs();
        settle();
        n_checks++;
        if (stall_cnt_b !== 2'd3) begin n_errors++; $display("FAIL sat_stall_b got=%0d exp=3", stall_cnt_b); end
        n_checks++;
        if (stall_cnt_a !== 16'd5) begin n_errors++; $display("FAIL sat_stall_a got=%0d exp=5", stall_cnt_a); end
    endtask

    // Reference model: per instance, an error flag, a run length of consecutive frozen
    // edges and plain integer event counts clipped at the counter maximum.
    bit err_m    [2];
    int frozen_m [2];
    int stalls_m [2];
    int flushes_m[2];
    int tmo_m    [2] = '{16, 4};
    int max_m    [2] = '{65535, 3};

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (mem_regWrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_regWrite && wb_rd != 0 && wb_rd == rs)    return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_loaduse();
        return ex_memRead && ex_rd != 0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [11:0] ref_ctl(input int k);
        logic [11:0] c;
        bit frz;
        frz = mem_req && !mem_ready;
        if (!rst_n)               c = C_RESET;
        else if (err_m[k])        c = C_ERROR;
        else if (frz)             c = C_FROZEN;
        else if (ex_branch_taken) c = C_BRANCH;
        else if (ref_loaduse())   c = C_LOADUSE;
        else                      c = C_NORMAL;
        c[4] = err_m[k];
        if (rst_n) c[3:0] = {ref_fwd(ex_rs1), ref_fwd(ex_rs2)};
        return c;
    endfunction

    task automatic ref_edge(input int k);
        bit frz;
        frz = mem_req && !mem_ready;
        if (!rst_n) begin
            err_m[k] = 0; frozen_m[k] = 0; stalls_m[k] = 0; flushes_m[k] = 0;
        end else if (!err_m[k]) begin
            if (frz) begin
                if (frozen_m[k] == tmo_m[k]) err_m[k] = 1;
                else frozen_m[k]++;
                stalls_m[k] = (stalls_m[k] < max_m[k]) ? stalls_m[k] + 1 : max_m[k];
            end else begin
                frozen_m[k] = 0;
                if (ex_branch_taken)    flushes_m[k] = (flushes_m[k] < max_m[k]) ? flushes_m[k] + 1 : max_m[k];
                else if (ref_loaduse()) stalls_m[k]  = (stalls_m[k]  < max_m[k]) ? stalls_m[k]  + 1 : max_m[k];
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] ea, eb;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            err_m[k] = 0; frozen_m[k] = 0; stalls_m[k] = 0; flushes_m[k] = 0;
        end
        for (int i = 0; i < 3000; i++) begin
            rst_n           = ($urandom_range(0, 99) >= 2);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom_range(0, 1));
            id_use_rs2      = 1'($urandom_range(0, 1));
            ex_rd           = 5'($urandom_range(0, 3));
            ex_memRead      = ($urandom_range(0, 99) < 40);
            ex_regWrite     = 1'($urandom_range(0, 1));
            ex_rs1          = 5'($urandom_range(0, 3));
            ex_rs2          = 5'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 99) < 20);
            mem_rd          = 5'($urandom_range(0, 3));
            mem_regWrite    = 1'($urandom_range(0, 1));
            mem_req         = ($urandom_range(0, 99) < 35);
            mem_ready       = 1'($urandom_range(0, 1));
            wb_rd           = 5'($urandom_range(0, 3));
            wb_regWrite     = 1'($urandom_range(0, 1));
            settle();
            ea = ref_ctl(0);
            eb = ref_ctl(1);
            n_checks++;
            if (ctl_a !== ea) begin n_errors++; $display("FAIL rnd_ctl_a i=%0d got=%b exp=%b", i, ctl_a, ea); end
            n_checks++;
            if (ctl_b !== eb) begin n_errors++; $display("FAIL rnd_ctl_b i=%0d got=%b exp=%b", i, ctl_b, eb); end
            n_checks++;
            if (stall_cnt_a !== 16'(stalls_m[0]) || flush_cnt_a !== 16'(flushes_m[0])) begin
                n_errors++;
                $display("FAIL rnd_cnt_a i=%0d stall=%0d flush=%0d exp=%0d,%0d",
                         i, stall_cnt_a, flush_cnt_a, stalls_m[0], flushes_m[0]);
            end
            n_checks++;
            if (stall_cnt_b !== 2'(stalls_m[1]) || flush_cnt_b !== 2'(flushes_m[1])) begin
                n_errors++;
                $display("FAIL rnd_cnt_b i=%0d stall=%0d flush=%0d exp=%0d,%0d",
                         i, stall_cnt_b, flush_cnt_b, stalls_m[1], flushes_m[1]);
            end
            @(posedge clk);
            ref_edge(0);
            ref_edge(1);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_mem_wait();
        test_timeout();
        test_forwarding();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
